pi_req_queue: RTL
=================

Name: pi_req_queue

Overview:
- Upstream stage of the 68k bus state machine; it consumes the Pi register-write protocol carried on the Pi GPIO pins.
- Synchronises the Pi WR strobe and stages the DATA_LO, DATA_HI and ADDR_LO words.
- A write to ADDR_HI pushes one complete bus request into a small FIFO. The bus FSM pops requests and reports completion, which lets the Pi post writes while a bus cycle is still in flight.
- Drives the request-active indication returned to the Pi (GPIO3 path).

Parameters:
- DEPTH, 4: FIFO entries. Power of two, minimum 2.
- AW, 2: log2(DEPTH). Also the pointer width.

Ports:
- SYSCLK  in  1  system clock (PLL clock domain)
- RESET  in  1  asynchronous, active-high reset
- PI_WR  in  1  raw Pi write strobe, active low, asynchronous
- PI_A  in  3  Pi register address (PI_REG_* codes from global.vh)
- PI_DATA  in  16  Pi data bus input
- REQ_VALID  out  1  head entry available
- REQ_ADDR  out  24  head byte address
- REQ_WDATA  out  32  head write data
- REQ_SIZE  out  2  head size code (bit0 = 16-bit, bit1 = second word)
- REQ_READ  out  1  head is a read
- REQ_FC  out  3  head function code
- REQ_POP  in  1  bus FSM takes the head; legal only when REQ_VALID=1
- REQ_DONE  in  1  one-cycle pulse when the popped request completes on the bus
- CTRL_WE  out  1  one-cycle pulse on a PI_REG_CONTROL write
- CTRL_DATA  out  16  PI_DATA captured with CTRL_WE
- BUSY  out  1  requests queued or in flight
- FULL  out  1  count == DEPTH
- OVERFLOW  out  1  sticky: an ADDR_HI push was dropped
- CLR_OVF  in  1  clears OVERFLOW

Behaviour:
- Reset values: all outputs 0. FIFO empty; pointers, count and in-flight counter are 0; staging registers are 0. Reset is asynchronous and applies immediately, including mid-transfer; all queued entries are discarded.
- Synchronisation: PI_WR passes through two flops (wr_a, wr_b) on posedge SYSCLK. A write event is wr_b & ~wr_a. PI_A and PI_DATA are sampled in the same cycle as the event; the Pi holds them stable across WR low.
- Event decode:
  - DATA_LO: stage_wdata[15:0] <= PI_DATA.
  - DATA_HI: stage_wdata[31:16] <= PI_DATA.
  - ADDR_LO: stage_addr[15:0] <= PI_DATA.
  - ADDR_HI: push the entry {fc=PI_DATA[13:11], read=PI_DATA[10], size=PI_DATA[9:8], addr={PI_DATA[7:0], stage_addr[15:0]}, wdata=stage_wdata}.
  - CONTROL: CTRL_WE=1 for one cycle, CTRL_DATA=PI_DATA.
  - Any other address: ignored.
- Latency:
  - Edge on PI_WR to event: 2–3 SYSCLK.
  - Push to REQ_VALID on an empty FIFO: 1 cycle (registered head, show-ahead).
- FIFO:
  - Circular buffer with wrap-around pointers and a count of width AW+1.
  - Outputs come from the head entry, registered.
  - Push and pop in the same cycle: count is unchanged and both proceed, including when full.
  - Push when full with no pop: entry dropped, OVERFLOW <= 1. OVERFLOW is held until CLR_OVF. If CLR_OVF and a drop coincide, set wins.
  - REQ_POP when empty is ignored; it is an assertion in simulation.
- In-flight counter:
  - +1 on REQ_POP, −1 on REQ_DONE; simultaneous pop and done leaves it unchanged.
  - REQ_DONE when the counter is 0 is ignored.
  - BUSY = (count != 0) | (inflight != 0). BUSY falls in the cycle after the last REQ_DONE.
- Ordering: strict FIFO order. A read is never reordered past earlier writes.
- Staging registers persist after a push. The Pi may issue repeated ADDR_HI writes to reuse the address low word and write data.

Optional Feature:
- Macro: PI_REQ_QUEUE_POSTED_EN.
- Defined: posted-write operation as described above.
- Undefined: non-posted operation with an effective depth of 1.
  - An ADDR_HI push is accepted only when count==0 and inflight==0; otherwise it is dropped and OVERFLOW is set.
  - FULL = BUSY.
  - FIFO storage reduces to a single register; DEPTH is ignored.

Decomposition:
- Shared package (extension of global.vh):
  - PI_REG_* address codes.
  - Request field offsets: fc 13:11, read 10, size 9:8, addr_hi 7:0.
  - Entry width localparam: 62 bits.
- One sub-module: pi_req_fifo. Generic synchronous FIFO, 62-bit wide, DEPTH entries, with push/pop/full/empty/count outputs.
- The top of pi_req_queue holds the WR synchroniser, decode, staging, overflow flag and in-flight counter.

Test Plan:
- Single write:
  - Stimulus: DATA_LO=0x1234, DATA_HI=0xABCD, ADDR_LO=0x0100, ADDR_HI=0x0501.
  - Required response: REQ_VALID=1 with ADDR=0x010100, WDATA=0xABCD1234, SIZE=1, READ=1, FC=0. BUSY stays 1 until REQ_DONE, then falls to 0.
- Fill and overflow (DEPTH=4):
  - Stimulus: five ADDR_HI pushes with no pops.
  - Required response: FULL=1 after the 4th push; the 5th push sets OVERFLOW. Popping yields the addresses of pushes 1–4 in order. CLR_OVF clears OVERFLOW.
- Simultaneous push and pop when full:
  - Required response: count stays 4, OVERFLOW stays 0, and the new entry emerges 4th.
- CONTROL write:
  - Stimulus: write 0x8001 to the CONTROL address.
  - Required response: exactly one CTRL_WE pulse with CTRL_DATA=0x8001; the FIFO is unchanged.
- Reset mid-operation:
  - Stimulus: 3 entries queued and 1 in flight, then RESET asserted.
  - Required response: REQ_VALID, BUSY, FULL and OVERFLOW are 0 immediately; the next push appears as the sole entry.
- Non-posted build (PI_REQ_QUEUE_POSTED_EN undefined):
  - Stimulus: a second ADDR_HI before REQ_DONE.
  - Required response: the second push is dropped and OVERFLOW=1. After REQ_DONE, the next push is accepted.

Source files
------------

// File: rtl/pi_req_queue_pkg.sv
// Shared definitions for the Pi request queue: Pi register address codes,
// the bit layout of the ADDR_HI word and the packed queue entry.
package pi_req_queue_pkg;

    // Pi register address codes
    localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
    localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
    localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
    localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;
    localparam logic [2:0] PI_REG_CONTROL = 3'd4;

    // Field positions inside the ADDR_HI word
    localparam int REQ_FC_MSB      = 13;
    localparam int REQ_FC_LSB      = 11;
    localparam int REQ_READ_BIT    = 10;
    localparam int REQ_SIZE_MSB    = 9;
    localparam int REQ_SIZE_LSB    = 8;
    localparam int REQ_ADDR_HI_MSB = 7;
    localparam int REQ_ADDR_HI_LSB = 0;

    localparam int REQ_ENTRY_W = 62;

    // One complete bus request as held in the queue
    typedef struct packed {
        logic [2:0]  fc;
        logic        read;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/pi_req_fifo.sv
// Generic show-ahead synchronous FIFO. The head entry is presented on dout
// whenever the FIFO is non-empty and reads as zero when empty. A push into a
// full FIFO is only accepted together with a pop; otherwise it is ignored.
module pi_req_fifo
    import pi_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = REQ_ENTRY_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; entries need no reset because dout is gated by empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy count; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pi_req_queue.sv
// Pi register-write front end for the 68k bus state machine.
// Synchronises PI_WR, stages data/address words, and queues complete bus
// requests on each ADDR_HI write. Tracks requests in flight for BUSY.
// Build option PI_REQ_QUEUE_POSTED_EN: when defined, requests are posted into a
// DEPTH-entry FIFO; when undefined, a single request is accepted only while
// the queue is empty and nothing is in flight.
module pi_req_queue
    import pi_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        PI_WR,
    input  logic [2:0]  PI_A,
    input  logic [15:0] PI_DATA,
    output logic        REQ_VALID,
    output logic [23:0] REQ_ADDR,
    output logic [31:0] REQ_WDATA,
    output logic [1:0]  REQ_SIZE,
    output logic        REQ_READ,
    output logic [2:0]  REQ_FC,
    input  logic        REQ_POP,
    input  logic        REQ_DONE,
    output logic        CTRL_WE,
    output logic [15:0] CTRL_DATA,
    output logic        BUSY,
    output logic        FULL,
    output logic        OVERFLOW,
    input  logic        CLR_OVF
);

    if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_depth_check
        $error("pi_req_queue: DEPTH must be a power of two >= 2 and equal 2**AW");
    end

    logic        wr_a;
    logic        wr_b;
    logic        wr_evt;
    logic        push_req;
    logic        push_drop;
    logic        pop_ok;
    logic        done_ok;
    logic [31:0] stage_wdata;
    logic [15:0] stage_addr;
    logic [AW:0] q_count;
    logic [AW:0] inflight;
    req_t        push_entry;
    req_t        head;
    logic        head_valid;

    // Two-flop synchroniser on the raw strobe; event on the falling edge of WR
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            wr_a <= 1'b0;
            wr_b <= 1'b0;
        end else begin
            wr_a <= PI_WR;
            wr_b <= wr_a;
        end
    end

    assign wr_evt   = wr_b & ~wr_a;
    assign push_req = wr_evt & (PI_A == PI_REG_ADDR_HI);

    // Staging words; they persist so the Pi can reuse them across ADDR_HI writes
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            stage_wdata <= '0;
            stage_addr  <= '0;
        end else if (wr_evt) begin
            case (PI_A)
                PI_REG_DATA_LO: stage_wdata[15:0]  <= PI_DATA;
                PI_REG_DATA_HI: stage_wdata[31:16] <= PI_DATA;
                PI_REG_ADDR_LO: stage_addr         <= PI_DATA;
                default: ;
            endcase
        end
    end

    // Entry assembled from the ADDR_HI word and the staged words
    always_comb begin
        push_entry       = '0;
        push_entry.fc    = PI_DATA[REQ_FC_MSB:REQ_FC_LSB];
        push_entry.read  = PI_DATA[REQ_READ_BIT];
        push_entry.size  = PI_DATA[REQ_SIZE_MSB:REQ_SIZE_LSB];
        push_entry.addr  = {PI_DATA[REQ_ADDR_HI_MSB:REQ_ADDR_HI_LSB], stage_addr};
        push_entry.wdata = stage_wdata;
    end

`ifdef PI_REQ_QUEUE_POSTED_EN
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [REQ_ENTRY_W-1:0] fifo_dout;

    pi_req_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (REQ_ENTRY_W)
    ) u_fifo (
        .clk   (SYSCLK),
        .rst   (RESET),
        .push  (push_req),
        .pop   (REQ_POP),
        .din   (push_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    assign head       = req_t'(fifo_dout);
    assign head_valid = ~fifo_empty;
    assign push_drop  = push_req & fifo_full & ~pop_ok;
    assign FULL       = fifo_full;
`else
    logic single_valid;
    req_t single_entry;
    logic push_ok;

    // Non-posted: accept only when nothing is queued or on the bus
    assign push_ok   = push_req & ~single_valid & (inflight == '0);
    assign push_drop = push_req & ~push_ok;

    // Single-entry holding register
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            single_valid <= 1'b0;
            single_entry <= '0;
        end else if (push_ok) begin
            single_valid <= 1'b1;
            single_entry <= push_entry;
        end else if (pop_ok) begin
            single_valid <= 1'b0;
        end
    end

    assign head       = single_valid ? single_entry : '0;
    assign head_valid = single_valid;
    assign q_count    = {{AW{1'b0}}, single_valid};
    assign FULL       = BUSY;
`endif

    assign pop_ok  = REQ_POP & head_valid;
    assign done_ok = REQ_DONE & (inflight != '0);

    // Requests popped by the bus FSM but not yet reported complete
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            inflight <= '0;
        end else begin
            case ({pop_ok, done_ok})
                2'b10:   inflight <= inflight + (AW+1)'(1);
                2'b01:   inflight <= inflight - (AW+1)'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as the clear keeps it set
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            OVERFLOW <= 1'b0;
        end else if (push_drop) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

    // CONTROL register write strobe with its data word
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            CTRL_WE   <= 1'b0;
            CTRL_DATA <= '0;
        end else begin
            CTRL_WE <= wr_evt & (PI_A == PI_REG_CONTROL);
            if (wr_evt && (PI_A == PI_REG_CONTROL)) begin
                CTRL_DATA <= PI_DATA;
            end
        end
    end

    assign REQ_VALID = head_valid;
    assign REQ_ADDR  = head.addr;
    assign REQ_WDATA = head.wdata;
    assign REQ_SIZE  = head.size;
    assign REQ_READ  = head.read;
    assign REQ_FC    = head.fc;
    assign BUSY      = (q_count != '0) | (inflight != '0);

    // The bus FSM must only pop when a head entry is present
    a_pop_when_valid: assert property (@(posedge SYSCLK) disable iff (RESET) REQ_POP |-> REQ_VALID);

endmodule
